xmem_ext_arb: RTL and testbench

- Round-robin arbiter that shares the external access port of a Versat data memory among N_REQ requesters, e.g. host CPU and DMA engine.
- Drives the memory's valid/we/addr/data inputs and tracks each read through the memory's fixed read latency. Returned data is steered back to the requester that issued the read.
- Blocks all new external accesses while the data engine is running, so external traffic never collides with address-generator traffic.

---
 rtl/xmem_ext_arb_if.sv | 30 +++
 rtl/xmem_ext_arb.sv | 128 ++++++++++++
 tb/tb_xmem_ext_arb.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xmem_ext_arb_if.sv
// Bundle between the external-port arbiter, its requesters and the Versat data memory.
// The master modport is the arbiter side; the slave modport is requesters plus memory.
interface xmem_ext_arb_if #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_valid;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    modport master (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/xmem_ext_arb.sv
// Round-robin arbiter for the Versat data-memory external port; read data is
// steered back to its issuer through a fixed-latency tag pipeline.
module xmem_ext_arb #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           eng_busy,
    xmem_ext_arb_if.master bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  iss_idx_q, iss_idx_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [RD_LAT-1:0] pv_q;
    logic [IDX_W-1:0]  pidx_q [RD_LAT];

    logic [N_REQ-1:0]  gnt_c;
    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic              rd_push;
    logic [ADDR_W-1:0] addr_a  [N_REQ];
    logic [DATA_W-1:0] wdata_a [N_REQ];

    // Unpack the flat per-requester buses
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            addr_a[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = bus.req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search from ptr+1, gated by reset and engine activity
    always_comb begin
        gnt_c    = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        if (rst && !eng_busy) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand_idx = IDX_W'((32'(ptr_q) + k) % N_REQ);
                if (!gnt_any && bus.req[cand_idx]) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = cand_idx;
                end
            end
        end
        if (gnt_any) begin
            gnt_c[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        iss_idx_d   = iss_idx_q;
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        if (gnt_any) begin
            ptr_d       = gnt_idx;
            iss_idx_d   = gnt_idx;
            mem_valid_d = 1'b1;
            mem_we_d    = bus.req_we[gnt_idx];
            mem_addr_d  = addr_a[gnt_idx];
            mem_wdata_d = wdata_a[gnt_idx];
        end
        // Pipeline head lines up with the word currently on mem_rdata
        if (pv_q[RD_LAT-1]) begin
            rvalid_d = N_REQ'(1) << pidx_q[RD_LAT-1];
            rdata_d  = bus.mem_rdata;
        end
    end

    assign rd_push = mem_valid_q & ~mem_we_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= IDX_W'(N_REQ - 1);
            iss_idx_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            pv_q        <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                pidx_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            iss_idx_q   <= iss_idx_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            pv_q[0]     <= rd_push;
            pidx_q[0]   <= iss_idx_q;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                pv_q[s]   <= pv_q[s-1];
                pidx_q[s] <= pidx_q[s-1];
            end
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_xmem_ext_arb.sv
// Directed bench for xmem_ext_arb: arbitration vector table plus read-return,
// engine-block and reset corner sequences against a 3-cycle memory model.
module tb_xmem_ext_arb;
    localparam int unsigned N_REQ  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned RD_LAT = 3;
    localparam int NV = 15;

    logic clk = 1'b0;
    logic rst;
    logic eng_busy;

    xmem_ext_arb_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    xmem_ext_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .eng_busy (eng_busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Memory model: word for a read strobe appears on mem_rdata three cycles later
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        if (bus.mem_valid && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rd_p0         <= bus.mem_valid ? mem[bus.mem_addr] : 32'hBAD0_BAD0;
        rd_p1         <= rd_p0;
        bus.mem_rdata <= rd_p1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_one(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wd);
        bus.req                        = '0;
        bus.req[idx]                   = 1'b1;
        bus.req_we[idx]                = we;
        bus.req_addr[idx*ADDR_W +: ADDR_W] = addr;
        bus.req_wdata[idx*DATA_W +: DATA_W] = wd;
    endtask

    typedef struct {
        logic [1:0] req;
        logic       busy;
        logic [1:0] exp_gnt;
    } vec_t;

    vec_t vecs [NV];
    logic [1:0]        prev;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wd;

    initial begin
        vecs[0]  = '{2'b11, 1'b0, 2'b01};
        vecs[1]  = '{2'b11, 1'b0, 2'b10};
        vecs[2]  = '{2'b11, 1'b0, 2'b01};
        vecs[3]  = '{2'b11, 1'b0, 2'b10};
        vecs[4]  = '{2'b11, 1'b0, 2'b01};
        vecs[5]  = '{2'b11, 1'b0, 2'b10};
        vecs[6]  = '{2'b10, 1'b1, 2'b00};
        vecs[7]  = '{2'b10, 1'b0, 2'b10};
        vecs[8]  = '{2'b10, 1'b0, 2'b10};
        vecs[9]  = '{2'b01, 1'b0, 2'b01};
        vecs[10] = '{2'b01, 1'b0, 2'b01};
        vecs[11] = '{2'b00, 1'b0, 2'b00};
        vecs[12] = '{2'b11, 1'b0, 2'b10};
        vecs[13] = '{2'b11, 1'b1, 2'b00};
        vecs[14] = '{2'b01, 1'b0, 2'b01};

        rst           = 1'b0;
        eng_busy      = 1'b0;
        bus.req       = 2'b11;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state
        #2;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        check("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b1;

        // Arbitration table: all writes so no read returns are expected
        bus.req_we    = 2'b11;
        bus.req_addr  = {10'h021, 10'h010};
        bus.req_wdata = {32'h0000_00B1, 32'h0000_00A0};
        exp_addr      = '0;
        exp_wd        = '0;
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                prev = vecs[i-1].exp_gnt;
                if (prev != 2'b00) begin
                    exp_addr = prev[1] ? 10'h021 : 10'h010;
                    exp_wd   = prev[1] ? 32'h0000_00B1 : 32'h0000_00A0;
                end
                check($sformatf("tbl%0d_mem_valid", i-1), 32'(bus.mem_valid), 32'(|prev));
                check($sformatf("tbl%0d_mem_we", i-1), 32'(bus.mem_we), 32'(|prev));
                check($sformatf("tbl%0d_mem_addr", i-1), 32'(bus.mem_addr), 32'(exp_addr));
                check($sformatf("tbl%0d_mem_wdata", i-1), bus.mem_wdata, exp_wd);
                check($sformatf("tbl%0d_rvalid", i-1), 32'(bus.rvalid), 32'h0);
            end
            if (i < NV) begin
                bus.req  = vecs[i].req;
                eng_busy = vecs[i].busy;
                #1;
                check($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].exp_gnt));
            end
        end
        bus.req  = '0;
        eng_busy = 1'b0;

        // Preload mem[5] through requester 1, then reset again
        @(negedge clk);
        drive_one(1, 1'b1, 10'd5, 32'hDEAD_BEEF);
        #1;
        check("pre_gnt", 32'(bus.gnt), 32'h2);
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Single read from requester 0
        @(negedge clk);
        drive_one(0, 1'b0, 10'd5, 32'h0);
        #1;
        check("rd_gnt", 32'(bus.gnt), 32'h1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("rd_mem_valid", 32'(bus.mem_valid), 32'h1);
                check("rd_mem_we", 32'(bus.mem_we), 32'h0);
                check("rd_mem_addr", 32'(bus.mem_addr), 32'd5);
                bus.req = '0;
            end
            check($sformatf("rd_rvalid_c%0d", c), 32'(bus.rvalid), (c == 5) ? 32'h1 : 32'h0);
            if (c == 5) check("rd_rdata", bus.rdata, 32'hDEAD_BEEF);
        end

        // Write from 0 then read of same address from 1
        @(negedge clk);
        drive_one(0, 1'b1, 10'd2, 32'h11);
        #1;
        check("mix_gnt_w", 32'(bus.gnt), 32'h1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("mix_w_mem_we", 32'(bus.mem_we), 32'h1);
                check("mix_w_mem_wdata", bus.mem_wdata, 32'h11);
                drive_one(1, 1'b0, 10'd2, 32'h0);
                #1;
                check("mix_gnt_r", 32'(bus.gnt), 32'h2);
            end else begin
                if (c == 2) begin
                    check("mix_r_mem_we", 32'(bus.mem_we), 32'h0);
                    bus.req = '0;
                end
                check($sformatf("mix_rvalid_c%0d", c), 32'(bus.rvalid), (c == 6) ? 32'h2 : 32'h0);
                if (c == 6) check("mix_rdata", bus.rdata, 32'h11);
            end
        end

        // Engine block with a read already in flight
        @(negedge clk);
        drive_one(0, 1'b0, 10'd5, 32'h0);
        #1;
        check("eng_gnt0", 32'(bus.gnt), 32'h1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("eng_mem_valid_c%0d", c), 32'(bus.mem_valid), (c == 1) ? 32'h1 : 32'h0);
            check($sformatf("eng_rvalid_c%0d", c), 32'(bus.rvalid), (c == 5) ? 32'h1 : 32'h0);
            if (c == 5) check("eng_rdata", bus.rdata, 32'hDEAD_BEEF);
            eng_busy = 1'b1;
            if (c == 1) drive_one(1, 1'b0, 10'd2, 32'h0);
            #1;
            check($sformatf("eng_gnt_c%0d", c), 32'(bus.gnt), 32'h0);
        end
        @(negedge clk);
        check("eng_mem_valid_c11", 32'(bus.mem_valid), 32'h0);
        eng_busy = 1'b0;
        #1;
        check("eng_gnt_release", 32'(bus.gnt), 32'h2);
        for (int c = 12; c <= 17; c++) begin
            @(negedge clk);
            if (c == 12) begin
                check("eng_rel_mem_valid", 32'(bus.mem_valid), 32'h1);
                check("eng_rel_mem_addr", 32'(bus.mem_addr), 32'd2);
                bus.req = '0;
            end
            check($sformatf("eng_rel_rvalid_c%0d", c), 32'(bus.rvalid), (c == 16) ? 32'h2 : 32'h0);
            if (c == 16) check("eng_rel_rdata", bus.rdata, 32'h11);
        end

        // Reset while a read is in flight
        @(negedge clk);
        drive_one(0, 1'b0, 10'd5, 32'h0);
        #1;
        check("mrst_gnt0", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        check("mrst_mem_valid", 32'(bus.mem_valid), 32'h1);
        bus.req = '0;
        @(negedge clk);
        rst           = 1'b0;
        bus.req       = 2'b11;
        bus.req_we    = 2'b11;
        bus.req_addr  = {10'h031, 10'h030};
        bus.req_wdata = {32'h0000_0C1, 32'h0000_0C0};
        #1;
        check("mrst_gnt", 32'(bus.gnt), 32'h0);
        check("mrst_rvalid", 32'(bus.rvalid), 32'h0);
        check("mrst_rdata", bus.rdata, 32'h0);
        check("mrst_mem_valid0", 32'(bus.mem_valid), 32'h0);
        check("mrst_mem_we", 32'(bus.mem_we), 32'h0);
        check("mrst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("mrst_mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_first_gnt", 32'(bus.gnt), 32'h1);
        for (int c = 4; c <= 9; c++) begin
            @(negedge clk);
            if (c == 4) begin
                check("mrst_post_mem_addr", 32'(bus.mem_addr), 32'h030);
                bus.req = '0;
            end
            check($sformatf("mrst_rvalid_c%0d", c), 32'(bus.rvalid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
